// File: rtl/multi_port_register_file_pkg.sv
// Shared types and default sizing for the multi-port register file and its scoreboard.
`default_nettype none
package multi_port_register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_REG_NUMBER = 32;
  localparam int DEFAULT_ADDR_WIDTH = $clog2(DEFAULT_REG_NUMBER);
  localparam int ZERO_REG           = 0;
  localparam logic TRUE             = 1'b1;
  localparam logic RST_ACTIVE       = 1'b0;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] RegAddr;
  typedef logic [DEFAULT_REG_NUMBER-1:0] RegPendingVector;

endpackage
`default_nettype wire

// File: rtl/register_scoreboard.sv
// Pending-write scoreboard: flush > issue > write-back clear priority, plus a popcount of pending bits.
`default_nettype none
module register_scoreboard
  import multi_port_register_file_pkg::*;
#(
  parameter int REG_NUMBER  = DEFAULT_REG_NUMBER,
  parameter int WRITE_PORTS = 1,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WRITE_PORTS-1:0]              w_enable,
  input  logic [WRITE_PORTS*$clog2(REG_NUMBER)-1:0] w_addr,
  input  logic                                issue_enable,
  input  logic [$clog2(REG_NUMBER)-1:0]       issue_addr,
  input  logic                                flush,
  output logic [REG_NUMBER-1:0]               pending,
  output logic [$clog2(REG_NUMBER+1)-1:0]     pending_count
);

  localparam int AW = $clog2(REG_NUMBER);
  localparam int CW = $clog2(REG_NUMBER + 1);

  logic [REG_NUMBER-1:0] pending_d;
  logic [REG_NUMBER-1:0] pending_q;

  // Later assignments win, so the code order encodes the priority.
  always_comb begin
    pending_d = pending_q;
    for (int j = 0; j < WRITE_PORTS; j++) begin
      if (w_enable[j]) pending_d[w_addr[j*AW +: AW]] = 1'b0;
    end
    if (issue_enable) pending_d[issue_addr] = 1'b1;
    if (flush) pending_d = '0;
    if (ZERO_REG_EN != 0) pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  always_comb begin
    pending_count = '0;
    for (int i = 0; i < REG_NUMBER; i++) begin
      pending_count = pending_count + CW'(pending_q[i]);
    end
  end

  assign pending = pending_q;

endmodule
`default_nettype wire

// File: rtl/multi_port_register_file.sv
// Multi-port integer register file with same-cycle write bypass and a RAW-hazard scoreboard.
`default_nettype none
module multi_port_register_file
  import multi_port_register_file_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int REG_NUMBER  = DEFAULT_REG_NUMBER,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1,
  parameter int ZERO_REG_EN = 1,
  parameter int BYPASS_EN   = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [READ_PORTS*$clog2(REG_NUMBER)-1:0]   rsAddr,
  output logic [READ_PORTS*DATA_WIDTH-1:0]           rsData,
  output logic [READ_PORTS-1:0]                      rsReady,
  input  logic [WRITE_PORTS-1:0]                     wEnable,
  input  logic [WRITE_PORTS*$clog2(REG_NUMBER)-1:0]  wAddr,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0]          wData,
  input  logic                                       issueEnable,
  input  logic [$clog2(REG_NUMBER)-1:0]              issueAddr,
  input  logic                                       flush,
  output logic [$clog2(REG_NUMBER+1)-1:0]            pendingCount
);

  localparam int AW = $clog2(REG_NUMBER);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [REG_NUMBER];
  logic [DATA_WIDTH-1:0] regs_d [REG_NUMBER];
  logic [REG_NUMBER-1:0] pending;
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_addr;

  register_scoreboard #(
    .REG_NUMBER  (REG_NUMBER),
    .WRITE_PORTS (WRITE_PORTS),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .w_enable      (wEnable),
    .w_addr        (wAddr),
    .issue_enable  (issueEnable),
    .issue_addr    (issueAddr),
    .flush         (flush),
    .pending       (pending),
    .pending_count (pendingCount)
  );

  // Ascending port order makes the highest-indexed writer win on address collisions.
  always_comb begin
    regs_d  = regs_q;
    wr_addr = '0;
    for (int j = 0; j < WRITE_PORTS; j++) begin
      wr_addr = wAddr[j*AW +: AW];
      if (wEnable[j] && !(ZERO_REG_EN != 0 && wr_addr == ZERO_ADDR)) begin
        regs_d[wr_addr] = wData[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs_q <= '{default: '0};
    else      regs_q <= regs_d;
  end

  // Reset gating keeps bypassed write data off the read ports while reset is held.
  always_comb begin
    rsData  = '0;
    rsReady = '0;
    rd_addr = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      rd_addr = rsAddr[i*AW +: AW];
      rsData[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_addr];
      rsReady[i] = ~pending[rd_addr];
      if (BYPASS_EN != 0) begin
        for (int j = 0; j < WRITE_PORTS; j++) begin
          if (wEnable[j] && wAddr[j*AW +: AW] == rd_addr) begin
            rsData[i*DATA_WIDTH +: DATA_WIDTH] = wData[j*DATA_WIDTH +: DATA_WIDTH];
            rsReady[i] = TRUE;
          end
        end
      end
      if ((ZERO_REG_EN != 0 && rd_addr == ZERO_ADDR) || rst == RST_ACTIVE) begin
        rsData[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        rsReady[i] = TRUE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_port_register_file.sv
// Directed self-checking bench for multi_port_register_file (2 read ports, 2 write ports).
`default_nettype none
module tb_multi_port_register_file;
  import multi_port_register_file_pkg::*;

  logic        clk;
  logic        rst;
  logic [9:0]  rsAddr;
  logic [63:0] rsData;
  logic [1:0]  rsReady;
  logic [1:0]  wEnable;
  logic [9:0]  wAddr;
  logic [63:0] wData;
  logic        issueEnable;
  logic [4:0]  issueAddr;
  logic        flush;
  logic [5:0]  pendingCount;

  logic [31:0] rd0;
  logic [31:0] rd1;
  assign rd0 = rsData[31:0];
  assign rd1 = rsData[63:32];

  int n_cmp  = 0;
  int n_fail = 0;

  multi_port_register_file #(
    .DATA_WIDTH  (32),
    .REG_NUMBER  (32),
    .READ_PORTS  (2),
    .WRITE_PORTS (2),
    .ZERO_REG_EN (1),
    .BYPASS_EN   (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rsAddr       (rsAddr),
    .rsData       (rsData),
    .rsReady      (rsReady),
    .wEnable      (wEnable),
    .wAddr        (wAddr),
    .wData        (wData),
    .issueEnable  (issueEnable),
    .issueAddr    (issueAddr),
    .flush        (flush),
    .pendingCount (pendingCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wEnable     = 2'b00;
    issueEnable = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic test_reset();
    RegAddr a;
    rst = 1'b0;
    idle();
    wAddr = '0; wData = '0; issueAddr = '0; rsAddr = '0;
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      a = RegAddr'(k);
      rsAddr = {~a, a};
      #1;
      n_cmp++;
      if (rsData !== 64'h0 || rsReady !== 2'b11 || pendingCount !== 6'd0) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: got data=%h ready=%b cnt=%0d want 0/11/0", k, rsData, rsReady, pendingCount);
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wEnable = 2'b01; wAddr[4:0] = 5'd5; wData[31:0] = 32'hDEADBEEF; rsAddr[4:0] = 5'd5;
    #1;
    n_cmp++;
    if (rd0 !== 32'hDEADBEEF || rsReady[0] !== 1'b1) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h/%b want deadbeef/1", rd0, rsReady[0]);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (rd0 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_stored: got %h want deadbeef", rd0);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    wEnable = 2'b01; wAddr[4:0] = 5'd0; wData[31:0] = 32'h1234; rsAddr[4:0] = 5'd0;
    #1;
    n_cmp++;
    if (rd0 !== 32'h0 || rsReady[0] !== 1'b1) begin
      n_fail++; $display("FAIL zero_write_bypass: got %h/%b want 0/1", rd0, rsReady[0]);
    end
    @(negedge clk);
    idle();
    issueEnable = 1'b1; issueAddr = 5'd0;
    #1;
    n_cmp++;
    if (rd0 !== 32'h0) begin
      n_fail++; $display("FAIL zero_stored: got %h want 0", rd0);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (rd0 !== 32'h0 || rsReady[0] !== 1'b1 || pendingCount !== 6'd0) begin
      n_fail++; $display("FAIL zero_issue: got %h/%b cnt=%0d want 0/1/0", rd0, rsReady[0], pendingCount);
    end
  endtask

  task automatic test_same_addr_write();
    @(negedge clk);
    wEnable = 2'b11; wAddr = {5'd7, 5'd7}; wData = {32'h22, 32'h11}; rsAddr[9:5] = 5'd7;
    #1;
    n_cmp++;
    if (rd1 !== 32'h22) begin
      n_fail++; $display("FAIL dual_write_bypass: got %h want 00000022", rd1);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (rd1 !== 32'h22) begin
      n_fail++; $display("FAIL dual_write_stored: got %h want 00000022", rd1);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    issueEnable = 1'b1; issueAddr = 5'd3;
    @(negedge clk);
    idle();
    rsAddr[4:0] = 5'd3;
    #1;
    n_cmp++;
    if (rsReady[0] !== 1'b0 || pendingCount !== 6'd1) begin
      n_fail++; $display("FAIL issue_x3: got ready=%b cnt=%0d want 0/1", rsReady[0], pendingCount);
    end
    @(negedge clk);
    wEnable = 2'b01; wAddr[4:0] = 5'd3; wData[31:0] = 32'h99;
    issueEnable = 1'b1; issueAddr = 5'd3;
    #1;
    n_cmp++;
    if (rd0 !== 32'h99 || rsReady[0] !== 1'b1) begin
      n_fail++; $display("FAIL wb_issue_bypass: got %h/%b want 99/1", rd0, rsReady[0]);
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (rd0 !== 32'h99 || rsReady[0] !== 1'b0 || pendingCount !== 6'd1) begin
      n_fail++; $display("FAIL issue_beats_clear: got %h/%b cnt=%0d want 99/0/1", rd0, rsReady[0], pendingCount);
    end
    @(negedge clk);
    wEnable = 2'b10; wAddr[9:5] = 5'd3; wData[63:32] = 32'h77;
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (rd0 !== 32'h77 || rsReady[0] !== 1'b1 || pendingCount !== 6'd0) begin
      n_fail++; $display("FAIL wb_clear: got %h/%b cnt=%0d want 77/1/0", rd0, rsReady[0], pendingCount);
    end
  endtask

  task automatic test_flush();
    @(negedge clk); issueEnable = 1'b1; issueAddr = 5'd1;
    @(negedge clk); issueAddr = 5'd2;
    @(negedge clk); issueAddr = 5'd4;
    @(negedge clk);
    idle();
    rsAddr = {5'd4, 5'd1};
    #1;
    n_cmp++;
    if (pendingCount !== 6'd3 || rsReady !== 2'b00) begin
      n_fail++; $display("FAIL three_pending: got cnt=%0d ready=%b want 3/00", pendingCount, rsReady);
    end
    @(negedge clk);
    flush = 1'b1; issueEnable = 1'b1; issueAddr = 5'd6;
    @(negedge clk);
    idle();
    rsAddr = {5'd5, 5'd6};
    #1;
    n_cmp++;
    if (pendingCount !== 6'd0 || rsReady !== 2'b11 || rd1 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL flush: got cnt=%0d ready=%b x5=%h want 0/11/deadbeef", pendingCount, rsReady, rd1);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    issueEnable = 1'b1; issueAddr = 5'd9;
    wEnable = 2'b01; wAddr[4:0] = 5'd10; wData[31:0] = 32'hAAAA;
    @(negedge clk);
    idle();
    rsAddr = {5'd8, 5'd10};
    #1;
    n_cmp++;
    if (rd0 !== 32'hAAAA || pendingCount !== 6'd1) begin
      n_fail++; $display("FAIL pre_reset: got %h cnt=%0d want aaaa/1", rd0, pendingCount);
    end
    #1;
    rst = 1'b0;
    wEnable = 2'b01; wAddr[4:0] = 5'd8; wData[31:0] = 32'hBBBB;
    issueEnable = 1'b1; issueAddr = 5'd8;
    #1;
    n_cmp++;
    if (rsData !== 64'h0 || rsReady !== 2'b11 || pendingCount !== 6'd0) begin
      n_fail++; $display("FAIL async_reset: got %h/%b cnt=%0d want 0/11/0", rsData, rsReady, pendingCount);
    end
    @(negedge clk);
    rst = 1'b1;
    idle();
    #1;
    n_cmp++;
    if (rsData !== 64'h0 || pendingCount !== 6'd0) begin
      n_fail++; $display("FAIL reset_discard: got %h cnt=%0d want 0/0", rsData, pendingCount);
    end
    @(negedge clk);
    wEnable = 2'b01; wAddr[4:0] = 5'd10; wData[31:0] = 32'h5;
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (rd0 !== 32'h5) begin
      n_fail++; $display("FAIL post_reset_write: got %h want 5", rd0);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_same_addr_write();
    test_scoreboard();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
